multi_tick_divider: RTL and testbench

- Parametrised, multi-channel successor to the single fixed-ratio slow-clock divider.
- Produces NUM_CH independent divided outputs from the 100 MHz system clock. Each channel has:
  - a one-cycle tick enable, for use as a clock enable by downstream logic such as a TDM display scan or a counter step;
  - a 50%-duty slow_clk toggle output.
- Each channel's divisor is reprogrammable at run time through a valid/ready load port. A new divisor takes effect only at a period boundary, so no output glitches or truncated periods occur.

---
 rtl/multi_tick_divider.sv | 110 +++++++++++
 tb/tb_multi_tick_divider.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_divider.sv
// Purpose: NUM_CH independent programmable dividers, each giving a one-cycle tick and a 50%-duty slow clock.
// Latency: outputs are registered; a tick appears in the cycle after the edge that ends the period.
// Backpressure: load_ready_o stays low while a divisor waits for its channel's period boundary.
module multi_tick_divider #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 27,
   parameter int DEFAULT_DIV = 50_000_000,
   // Derived from NUM_CH; leave at its default.
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              sync_all_i,
   input  logic              load_valid_i,
   input  logic [CH_W-1:0]   load_ch_i,
   input  logic [CNT_W-1:0]  load_div_i,
   output logic              load_ready_o,
   output logic              load_err_o,
   output logic [NUM_CH-1:0] tick_o,
   output logic [NUM_CH-1:0] slow_clk_o
);

   localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CH_W:0]    NUM_CH_W = (CH_W+1)'(NUM_CH);

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  div_q [NUM_CH];
   logic [NUM_CH-1:0] tick_q;
   logic [NUM_CH-1:0] slow_q;
   logic              pend_vld_q;
   logic [CH_W-1:0]   pend_ch_q;
   logic [CNT_W-1:0]  pend_div_q;
   logic              load_err_q;

   logic              load_take_d;
   logic              load_bad_d;
   logic [NUM_CH-1:0] term_d;

   // Handshake decode and per-channel terminal-count detect.
   always_comb begin
      load_take_d = load_valid_i & ~pend_vld_q;
      load_bad_d  = (load_div_i == '0) | ({1'b0, load_ch_i} >= NUM_CH_W);
      term_d      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         term_d[i] = (cnt_q[i] == (div_q[i] - ONE));
      end
   end

   // Counters, divisors, outputs and the single pending-load slot; rst beats sync_all beats counting.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
            div_q[i] <= DEF_DIV;
         end
         tick_q     <= '0;
         slow_q     <= '0;
         pend_vld_q <= 1'b0;
         pend_ch_q  <= '0;
         pend_div_q <= '0;
         load_err_q <= 1'b0;
      end else begin
         load_err_q <= load_take_d & load_bad_d;
         tick_q     <= '0;
         if (sync_all_i) begin
            // Phase-align everything; whatever divisor is waiting (or arriving now) lands immediately.
            slow_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
               cnt_q[i] <= '0;
            end
            if (pend_vld_q) begin
               div_q[pend_ch_q] <= pend_div_q;
            end else if (load_take_d & ~load_bad_d) begin
               div_q[load_ch_i] <= load_div_i;
            end
            pend_vld_q <= 1'b0;
         end else begin
            // A load taken on this edge only becomes visible to the terminal check from the next edge.
            if (load_take_d & ~load_bad_d) begin
               pend_vld_q <= 1'b1;
               pend_ch_q  <= load_ch_i;
               pend_div_q <= load_div_i;
            end
            if (en_i) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (term_d[i]) begin
                     cnt_q[i]  <= '0;
                     tick_q[i] <= 1'b1;
                     slow_q[i] <= ~slow_q[i];
                     if (pend_vld_q && (pend_ch_q == CH_W'(i))) begin
                        div_q[i]   <= pend_div_q;
                        pend_vld_q <= 1'b0;
                     end
                  end else begin
                     cnt_q[i] <= cnt_q[i] + ONE;
                  end
               end
            end
         end
      end
   end

   assign load_ready_o = ~pend_vld_q;
   assign load_err_o   = load_err_q;
   assign tick_o       = tick_q;
   assign slow_clk_o   = slow_q;

endmodule

// File: tb/tb_multi_tick_divider.sv
// Bench for multi_tick_divider: 3 channels, 8-bit counters, default divisor 4.
// A countdown-style reference model is compared against the DUT every cycle,
// and directed scenarios pin the model with hand-computed tick/slow_clk values.
module tb_multi_tick_divider;

   localparam int NCH  = 3;
   localparam int CW   = 8;
   localparam int DEFD = 4;
   localparam int CHW  = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b0;
   logic           sync_all = 1'b0;
   logic           load_valid = 1'b0;
   logic [CHW-1:0] load_ch = '0;
   logic [CW-1:0]  load_div = '0;
   logic           load_ready;
   logic           load_err;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] slow_clk;

   int checks = 0;
   int errors = 0;

   multi_tick_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEFD)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .sync_all_i(sync_all),
      .load_valid_i(load_valid), .load_ch_i(load_ch), .load_div_i(load_div),
      .load_ready_o(load_ready), .load_err_o(load_err),
      .tick_o(tick), .slow_clk_o(slow_clk));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // rem[i] = enabled edges still to come until channel i's next tick edge.
   int             rem [NCH];
   int             mdiv [NCH];
   logic [NCH-1:0] m_tick, m_slow;
   bit             m_pend, m_err, model_ok;
   int             m_pch, m_pdiv;
   int             cyc;
   bit             take, bad, was_pend;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            mdiv[i] = DEFD;
            rem[i]  = DEFD;
         end
         m_tick = '0; m_slow = '0; m_pend = 0; m_err = 0;
         cyc = 0; model_ok = 1;
      end else begin
         cyc++;
         take     = load_valid && !m_pend;
         bad      = (load_div == 0) || (load_ch >= NCH);
         m_err    = take && bad;
         was_pend = m_pend;
         m_tick   = '0;
         if (sync_all) begin
            if (m_pend) mdiv[m_pch] = m_pdiv;
            else if (take && !bad) mdiv[load_ch] = int'(load_div);
            m_pend = 0;
            m_slow = '0;
            for (int i = 0; i < NCH; i++) rem[i] = mdiv[i];
         end else begin
            if (en) begin
               for (int i = 0; i < NCH; i++) begin
                  rem[i]--;
                  if (rem[i] == 0) begin
                     m_tick[i] = 1'b1;
                     m_slow[i] = ~m_slow[i];
                     if (was_pend && m_pch == i) begin
                        mdiv[i] = m_pdiv;
                        m_pend  = 0;
                     end
                     rem[i] = mdiv[i];
                  end
               end
            end
            if (take && !bad) begin
               m_pend = 1; m_pch = int'(load_ch); m_pdiv = int'(load_div);
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("tick", 32'(tick), 32'(m_tick));
         chk("slow_clk", 32'(slow_clk), 32'(m_slow));
         chk("load_ready", 32'(load_ready), 32'(!m_pend));
         chk("load_err", 32'(load_err), 32'(m_err));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst = 1'b1; en = 1'b1; sync_all = 1'b0; load_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Hand-computed tables, index = cycle number after reset release.
   bit t0_tbl [1:12] = '{0,0,0,1,0,0,0,1,0,0,0,1};
   bit s0_tbl [1:12] = '{0,0,0,1,1,1,1,0,0,0,0,1};
   bit t1_tbl [1:12] = '{0,0,0,1,0,0,1,0,0,1,0,0};
   logic [NCH-1:0] t5_tbl [4:7] = '{3'b000, 3'b001, 3'b000, 3'b111};

   initial begin
      // Test 1: reset then default ticks.
      do_reset();
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_ready", 32'(load_ready), 32'd1);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("t1_tick0", 32'(tick[0]), 32'(t0_tbl[k]));
         chk("t1_slow0", 32'(slow_clk[0]), 32'(s0_tbl[k]));
      end

      // Test 2: reload ch1 with 3 at cycle 2.
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("t2_tick0", 32'(tick[0]), 32'(t0_tbl[k]));
         chk("t2_tick1", 32'(tick[1]), 32'(t1_tbl[k]));
         if (k == 3) chk("t2_ready_low", 32'(load_ready), 32'd0);
         if (k == 4) chk("t2_ready_back", 32'(load_ready), 32'd1);
         if (k == 2) begin load_valid = 1'b1; load_ch = 2'd1; load_div = 8'd3; end
         else load_valid = 1'b0;
      end

      // Test 3: rejected loads (zero divisor, out-of-range channel).
      load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd0;
      @(negedge clk);
      chk("t3_err_div0", 32'(load_err), 32'd1);
      chk("t3_ready_div0", 32'(load_ready), 32'd1);
      load_ch = 2'd3; load_div = 8'd5;
      @(negedge clk);
      chk("t3_err_ch", 32'(load_err), 32'd1);
      chk("t3_ready_ch", 32'(load_ready), 32'd1);
      load_valid = 1'b0;
      @(negedge clk);
      chk("t3_err_clear", 32'(load_err), 32'd0);
      repeat (8) @(negedge clk);

      // Test 4: en low for 5 edges mid-period delays the tick by 5.
      do_reset();
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k >= 7 && k <= 12) chk("t4_no_tick", 32'(tick), 32'd0);
         if (k == 12) chk("t4_slow_hold", 32'(slow_clk[0]), 32'd1);
         if (k == 13) begin
            chk("t4_late_tick", 32'(tick[0]), 32'd1);
            chk("t4_slow_toggle", 32'(slow_clk[0]), 32'd0);
         end
         if (k == 6) en = 1'b0;
         if (k == 11) en = 1'b1;
      end

      // Test 5: pending div 2 on ch0, then sync_all; Test 6: reset with a pending load.
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 2) chk("t5_ready_pend", 32'(load_ready), 32'd0);
         if (k == 3) begin
            chk("t5_sync_tick", 32'(tick), 32'd0);
            chk("t5_sync_slow", 32'(slow_clk), 32'd0);
            chk("t5_sync_ready", 32'(load_ready), 32'd1);
         end
         if (k >= 4 && k <= 7) chk("t5_tick_after_sync", 32'(tick), 32'(t5_tbl[k]));
         if (k == 9) chk("t6_ready_pend", 32'(load_ready), 32'd0);
         load_valid = (k == 1) || (k == 8);
         load_ch    = 2'd0;
         load_div   = (k == 1) ? 8'd2 : 8'd3;
         sync_all   = (k == 2);
      end
      load_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_tick", 32'(tick), 32'd0);
      chk("t6_rst_slow", 32'(slow_clk), 32'd0);
      chk("t6_rst_ready", 32'(load_ready), 32'd1);
      chk("t6_rst_err", 32'(load_err), 32'd0);
      rst = 1'b0;

      // Test 6 continued: default spacing restored; Test 7: load ch2 div 1 with sync_all.
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k <= 8) chk("t6_tick0", 32'(tick[0]), 32'(t0_tbl[k]));
         if (k == 9) begin
            chk("t7_ready", 32'(load_ready), 32'd1);
            chk("t7_slow2_sync", 32'(slow_clk[2]), 32'd0);
         end
         if (k >= 10) begin
            chk("t7_tick2", 32'(tick[2]), 32'd1);
            chk("t7_slow2", 32'(slow_clk[2]), (k == 11) ? 32'd0 : 32'd1);
         end
         load_valid = (k == 8);
         sync_all   = (k == 8);
         load_ch    = 2'd2;
         load_div   = 8'd1;
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
